// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Port indices, read-return owner tags and the default starvation limit.
package mem_arbiter_pkg;

    typedef enum logic {
        PORT_CPU    = 1'b0,
        PORT_LOADER = 1'b1
    } port_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_P0   = 2'd1,
        RD_P1   = 2'd2
    } rd_tag_t;

    localparam int DEFAULT_MAX_WAIT = 4;

endpackage

// File: rtl/mem_arbiter_arb_prio2.sv
// Two-input grant logic: fixed priority to port 0 with a starvation guard for port 1,
// or alternating priority on contention when MEM_ARBITER_ROUND_ROBIN_EN is defined.
module arb_prio2
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic sel1;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_winner;

    assign sel1 = req1 & (!req0 | (last_winner == PORT_CPU));

    always_ff @(posedge clock) begin
        if (reset)
            last_winner <= PORT_CPU;
        else if (gnt0)
            last_winner <= PORT_CPU;
        else if (gnt1)
            last_winner <= PORT_LOADER;
    end
`else
    logic [3:0] wait_cnt;
    logic       starve;

    assign starve = int'(wait_cnt) >= MAX_WAIT;
    assign sel1   = req1 & (!req0 | starve);

    // Counts consecutive cycles port 1 asked and lost; any gap in asking restarts it.
    always_ff @(posedge clock) begin
        if (reset || gnt1 || !req1)
            wait_cnt <= 4'd0;
        else if (wait_cnt != 4'hf)
            wait_cnt <= wait_cnt + 4'd1;
    end
`endif

    assign gnt0 = req0 & !sel1 & !reset;
    assign gnt1 = sel1 & !reset;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the CPU data port and the loader.
// Combinational grant; read data one cycle after grant; optional MEM_ARBITER_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18,
    parameter int MAX_WAIT  = DEFAULT_MAX_WAIT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [ADDR_SIZE-1:0] p0_addr,
    input  logic [WORD_SIZE-1:0] p0_wdata,
    output logic                 p0_gnt,
    output logic                 p0_rvalid,
    output logic [WORD_SIZE-1:0] p0_rdata,
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [ADDR_SIZE-1:0] p1_addr,
    input  logic [WORD_SIZE-1:0] p1_wdata,
    output logic                 p1_gnt,
    output logic                 p1_rvalid,
    output logic [WORD_SIZE-1:0] p1_rdata,
    output logic                 mem_write_enable,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_in,
    input  logic [WORD_SIZE-1:0] mem_out
);

    rd_tag_t              rd_pend;
    logic [WORD_SIZE-1:0] p0_rdata_q;
    logic [WORD_SIZE-1:0] p1_rdata_q;

    arb_prio2 #(.MAX_WAIT(MAX_WAIT)) u_arb (
        .clock (clock),
        .reset (reset),
        .req0  (p0_req),
        .req1  (p1_req),
        .gnt0  (p0_gnt),
        .gnt1  (p1_gnt)
    );

    assign mem_addr         = p1_gnt ? p1_addr  : p0_addr;
    assign mem_in           = p1_gnt ? p1_wdata : p0_wdata;
    assign mem_write_enable = (p0_gnt & p0_we) | (p1_gnt & p1_we);

    always_ff @(posedge clock) begin
        if (reset)
            rd_pend <= RD_NONE;
        else if (p0_gnt && !p0_we)
            rd_pend <= RD_P0;
        else if (p1_gnt && !p1_we)
            rd_pend <= RD_P1;
        else
            rd_pend <= RD_NONE;
    end

    // The RAM presents read data in the cycle after the grant, so the return is a
    // combinational pass-through; the hold registers keep it visible afterwards.
    assign p0_rvalid = (rd_pend == RD_P0) & !reset;
    assign p1_rvalid = (rd_pend == RD_P1) & !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            if (p0_rvalid)
                p0_rdata_q <= mem_out;
            if (p1_rvalid)
                p1_rdata_q <= mem_out;
        end
    end

    assign p0_rdata = p0_rvalid ? mem_out : (reset ? '0 : p0_rdata_q);
    assign p1_rdata = p1_rvalid ? mem_out : (reset ? '0 : p1_rdata_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a write-first synchronous RAM model.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [17:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [17:0] p0_rdata, p1_rdata;
    logic        mem_write_enable;
    logic [17:0] mem_addr, mem_in, mem_out;

    logic [17:0] ram [0:1023];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [17:0] a0, d0;
        logic        r1, w1;
        logic [17:0] a1, d1;
        logic        g0, g1, we;
        logic [17:0] ma;
        logic        v0;
        logic [17:0] rd0;
        logic        v1;
        logic [17:0] rd1;
    } vec_t;

    vec_t vecs [10];

    mem_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .p0_req           (p0_req),
        .p0_we            (p0_we),
        .p0_addr          (p0_addr),
        .p0_wdata         (p0_wdata),
        .p0_gnt           (p0_gnt),
        .p0_rvalid        (p0_rvalid),
        .p0_rdata         (p0_rdata),
        .p1_req           (p1_req),
        .p1_we            (p1_we),
        .p1_addr          (p1_addr),
        .p1_wdata         (p1_wdata),
        .p1_gnt           (p1_gnt),
        .p1_rvalid        (p1_rvalid),
        .p1_rdata         (p1_rdata),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_in           (mem_in),
        .mem_out          (mem_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Write-first single-port RAM, one cycle read latency.
    always @(posedge clock) begin
        if (mem_write_enable) begin
            ram[mem_addr[9:0]] <= mem_in;
            mem_out            <= mem_in;
        end else begin
            mem_out <= ram[mem_addr[9:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset    = v.rst;
        p0_req   = v.r0;
        p0_we    = v.w0;
        p0_addr  = v.a0;
        p0_wdata = v.d0;
        p1_req   = v.r1;
        p1_we    = v.w1;
        p1_addr  = v.a1;
        p1_wdata = v.d1;
    endtask

    task automatic both_read(input logic rst, input logic r1);
        reset    = rst;
        p0_req   = 1'b1;
        p0_we    = 1'b0;
        p0_addr  = 18'h00010;
        p0_wdata = 18'h0;
        p1_req   = r1;
        p1_we    = 1'b0;
        p1_addr  = 18'h00100;
        p1_wdata = 18'h0;
    endtask

    initial begin
        logic prev_g0, prev_g1, exp_g1;

        for (int i = 0; i < 1024; i++) ram[i] = 18'h0;
        mem_out = 18'h0;

        //          rst r0 w0 a0       d0        r1 w1 a1       d1        g0 g1 we ma       v0 rd0       v1 rd1
        vecs[0] = '{1, 1, 1, 'h00010, 'h00001, 1, 0, 'h00020, 'h0,     0, 0, 0, 'h00010, 0, 'h0,     0, 'h0};
        vecs[1] = '{0, 1, 1, 'h00010, 'h2A5A5, 0, 0, 'h00020, 'h0,     1, 0, 1, 'h00010, 0, 'h0,     0, 'h0};
        vecs[2] = '{0, 1, 0, 'h00010, 'h0,     0, 0, 'h0,     'h0,     1, 0, 0, 'h00010, 0, 'h0,     0, 'h0};
        vecs[3] = '{0, 0, 0, 'h0,     'h0,     0, 0, 'h0,     'h0,     0, 0, 0, 'h0,     1, 'h2A5A5, 0, 'h0};
        vecs[4] = '{0, 0, 0, 'h0,     'h0,     1, 1, 'h00100, 'h12345, 0, 1, 1, 'h00100, 0, 'h2A5A5, 0, 'h0};
        vecs[5] = '{0, 1, 0, 'h00100, 'h0,     0, 0, 'h0,     'h0,     1, 0, 0, 'h00100, 0, 'h2A5A5, 0, 'h0};
        vecs[6] = '{0, 0, 0, 'h0,     'h0,     0, 0, 'h0,     'h0,     0, 0, 0, 'h0,     1, 'h12345, 0, 'h0};
        vecs[7] = '{0, 0, 0, 'h0,     'h0,     1, 0, 'h00100, 'h0,     0, 1, 0, 'h00100, 0, 'h12345, 0, 'h0};
        vecs[8] = '{1, 0, 0, 'h0,     'h0,     0, 0, 'h0,     'h0,     0, 0, 0, 'h0,     0, 'h0,     0, 'h0};
        vecs[9] = '{0, 0, 0, 'h0,     'h0,     0, 0, 'h0,     'h0,     0, 0, 0, 'h0,     0, 'h0,     0, 'h0};

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            drive(vecs[i]);
            #2;
            chk($sformatf("v%0d.p0_gnt", i),    32'(p0_gnt),           32'(vecs[i].g0));
            chk($sformatf("v%0d.p1_gnt", i),    32'(p1_gnt),           32'(vecs[i].g1));
            chk($sformatf("v%0d.mem_we", i),    32'(mem_write_enable), 32'(vecs[i].we));
            chk($sformatf("v%0d.mem_addr", i),  32'(mem_addr),         32'(vecs[i].ma));
            chk($sformatf("v%0d.p0_rvalid", i), 32'(p0_rvalid),        32'(vecs[i].v0));
            chk($sformatf("v%0d.p0_rdata", i),  32'(p0_rdata),         32'(vecs[i].rd0));
            chk($sformatf("v%0d.p1_rvalid", i), 32'(p1_rvalid),        32'(vecs[i].v1));
            chk($sformatf("v%0d.p1_rdata", i),  32'(p1_rdata),         32'(vecs[i].rd1));
        end

        // Reset with both requesting, then continuous contention.
        @(negedge clock);
        both_read(1'b1, 1'b1);
        #2;
        chk("rst.p0_gnt", 32'(p0_gnt), 0);
        chk("rst.p1_gnt", 32'(p1_gnt), 0);
        chk("rst.mem_we", 32'(mem_write_enable), 0);
        chk("rst.p0_rvalid", 32'(p0_rvalid), 0);
        chk("rst.p1_rvalid", 32'(p1_rvalid), 0);

        prev_g0 = 1'b0;
        prev_g1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            both_read(1'b0, 1'b1);
            #2;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            exp_g1 = (i % 2 == 0);
`else
            exp_g1 = (i % 5 == 4);
`endif
            chk($sformatf("c%0d.p0_gnt", i), 32'(p0_gnt), 32'(!exp_g1));
            chk($sformatf("c%0d.p1_gnt", i), 32'(p1_gnt), 32'(exp_g1));
            chk($sformatf("c%0d.p0_rvalid", i), 32'(p0_rvalid), 32'(prev_g0));
            chk($sformatf("c%0d.p1_rvalid", i), 32'(p1_rvalid), 32'(prev_g1));
            if (prev_g0) chk($sformatf("c%0d.p0_rdata", i), 32'(p0_rdata), 32'h2A5A5);
            if (prev_g1) chk($sformatf("c%0d.p1_rdata", i), 32'(p1_rdata), 32'h12345);
            prev_g0 = !exp_g1;
            prev_g1 = exp_g1;
        end

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
        // Dropping p1_req for a cycle restarts its wait count.
        for (int j = 0; j < 9; j++) begin
            @(negedge clock);
            both_read(1'b0, (j != 3));
            #2;
            chk($sformatf("s%0d.p1_gnt", j), 32'(p1_gnt), 32'(j == 8));
            chk($sformatf("s%0d.p0_gnt", j), 32'(p0_gnt), 32'(j != 8));
        end
`endif

        // Reset one cycle after a p1 read grant suppresses its return.
        @(negedge clock);
        drive('{0, 0, 0, 'h0, 'h0, 1, 0, 'h00100, 'h0, 0, 0, 0, 'h0, 0, 'h0, 0, 'h0});
        #2;
        chk("mr.p1_gnt", 32'(p1_gnt), 1);
        @(negedge clock);
        drive('{1, 0, 0, 'h0, 'h0, 0, 0, 'h0, 'h0, 0, 0, 0, 'h0, 0, 'h0, 0, 'h0});
        #2;
        chk("mr.p1_rvalid_rst", 32'(p1_rvalid), 0);
        chk("mr.p1_rdata_rst", 32'(p1_rdata), 0);
        @(negedge clock);
        reset = 1'b0;
        #2;
        chk("mr.p1_rvalid_after", 32'(p1_rvalid), 0);
        chk("mr.p0_rvalid_after", 32'(p0_rvalid), 0);

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous data RAM between two requesters: port 0 is the processor data port, port 1 is the program/data loader (DMA).
- Per-cycle arbitration with a combinational grant.
- Read data returns one cycle after grant, tagged to the owner.
- Fixed priority to port 0, with a starvation guard that forces port 1 through after MAX_WAIT lost cycles.

Parameters:
- ADDR_SIZE, 18, address width.
- WORD_SIZE, 18, data width.
- MAX_WAIT, 4, consecutive lost cycles after which port 1 wins (1..15).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- p0_req  in  1  port 0 access request
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_SIZE  port 0 address
- p0_wdata  in  WORD_SIZE  port 0 write data
- p0_gnt  out  1  port 0 access accepted this cycle
- p0_rvalid  out  1  port 0 read data valid
- p0_rdata  out  WORD_SIZE  port 0 read data
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as port 0, for port 1
- mem_write_enable  out  1  RAM write strobe
- mem_addr  out  ADDR_SIZE  RAM address
- mem_in  out  WORD_SIZE  RAM write data
- mem_out  in  WORD_SIZE  RAM read data, valid one clock after address

Behaviour:
- Grant (combinational): sel1 = p1_req & (!p0_req | starve).
  - p0_gnt = p0_req & !sel1 & !reset.
  - p1_gnt = sel1 & !reset.
  - At most one grant per cycle.
- A request is consumed on a cycle where req & gnt.
  - A requester holds req/we/addr/wdata stable until granted.
  - Deasserting before grant is legal; the request is then dropped.
- Memory mux:
  - mem_addr and mem_in come from the granted port; port 0 when none is granted.
  - mem_write_enable = granted & we; 0 when idle or in reset.
- starve flag = (wait_cnt >= MAX_WAIT).
- wait_cnt (4-bit register):
  - Increments, saturating at 15, on each cycle with p1_req & !p1_gnt.
  - Clears on p1_gnt or !p1_req.
  - Reset value 0.
- Read return:
  - Registered owner tag rd_pend[1:0], set on a granted read.
  - Next cycle, pX_rvalid = 1 and pX_rdata = mem_out for the owner only.
  - The non-owner's rdata holds its last value; rdata is not cleared by rvalid falling.
  - Writes produce no rvalid.
- Back-to-back: a port may be granted every cycle. Read latency is fixed at exactly 1 cycle regardless of contention.
- Reset values: p0_rvalid = p1_rvalid = 0, p0_rdata = p1_rdata = 0, wait_cnt = 0, rd_pend = 0, both grants = 0.
- Reset mid-operation: a read granted in the cycle before reset does not produce rvalid; reset wins.
- Same address, write by one port then read by the other in the next cycle: the read returns the new data. This relies on RAM write-first ordering; the arbiter adds no forwarding.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- When defined:
  - wait_cnt and MAX_WAIT are ignored.
  - A 1-bit last_winner register (reset 0 = port 0) is updated on every grant.
  - On simultaneous requests, the port that is not last_winner wins.
  - Single-requester behaviour is unchanged.
- When undefined: fixed priority with the starvation guard, as above.

Decomposition:
- Package mem_arbiter_pkg:
  - Port index typedef: PORT_CPU = 0, PORT_LOADER = 1.
  - Owner tag enum: RD_NONE, RD_P0, RD_P1.
  - Default MAX_WAIT constant.
- One sub-module arb_prio2: the two-input grant logic and wait_cnt/last_winner state. The top level holds the mux and read-return pipeline.

Test Plan:
- Reset check: reset high with both ports requesting -> no gnt, mem_write_enable = 0, rvalid = 0; first cycle after reset release -> p0_gnt = 1.
- Port 0 only: write 0x2A5A5 to 0x00010, then read 0x00010 next cycle -> p0_gnt on both cycles; p0_rvalid one cycle after the read grant with p0_rdata = 0x2A5A5; p1_rvalid stays 0.
- Contention, MAX_WAIT = 4: both ports request continuously -> p0 granted cycles 0-3, p1 granted cycle 4, pattern repeats; wait_cnt clears on the p1 grant.
- Cross-port coherency: p1 writes 0x12345 to 0x00100 in cycle N, p0 reads 0x00100 in cycle N+1 -> p0_rdata = 0x12345 at N+2.
- Reset mid-read: p1 read granted in cycle N, reset asserted in N+1 -> p1_rvalid = 0 in N+1 and afterwards.
- With MEM_ARBITER_ROUND_ROBIN_EN defined, both ports requesting continuously -> grants alternate p1, p0, p1, ... starting from p1 after reset.
